detector_stream_arbiter: RTL and testbench
==========================================

DETECTOR_STREAM_ARBITER -- requirements
Module: detector_stream_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning word length in bits serialized per job (WIDTH >= 2).
REQ-002 SHALL have parameter CW, default $clog2(WIDTH+1), meaning hit-count width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0, req1  input  1 each  job request from requester 0 / 1, held high until the matching gnt.
REQ-007 data0, data1  input  WIDTH each  word to scan for requester 0 / 1, valid while the matching req is high.
REQ-008 gnt0, gnt1  output  1 each  one-cycle pulse: word accepted from requester 0 / 1.
REQ-009 det_clear  output  1  drives the shared sequence detector's reset input.
REQ-010 det_bit  output  1  drives the detector's serial input.
REQ-011 det_hit  input  1  the detector's Mealy output, combinational in det_bit.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 done  output  1  one-cycle pulse: result valid.
REQ-014 done_id  output  1  requester served by the current done.
REQ-015 hit_count  output  CW  number of det_hit cycles during the job.
REQ-016 any_hit  output  1  hit_count != 0, valid with done.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, SHIFT and DONE.
REQ-018 IDLE with no req: SHALL stay in IDLE.
REQ-019 IDLE with any req: SHALL latch the winner's data into shreg, set cur_id, zero bit_idx and hit_count, and go to CLEAR.
REQ-020 Arbitration SHALL be round-robin via a last_served flag; reset value 1, so req0 wins the first simultaneous request.
REQ-021 Arbitration with a single req: that requester wins regardless of last_served.
REQ-022 CLEAR SHALL last exactly one cycle: assert gnt[cur_id] and go to SHIFT.
REQ-023 det_clear SHALL be 1 in every state except SHIFT, so the detector starts each job in its idle state.
REQ-024 SHIFT, per cycle: det_bit = shreg[WIDTH-1] (MSB first).
REQ-025 SHIFT, per rising edge: hit_count += det_hit, shreg <<= 1, bit_idx += 1.
REQ-026 SHIFT SHALL last exactly WIDTH cycles; after the edge with bit_idx == WIDTH-1 the FSM goes to DONE.
REQ-027 hit_count SHALL NOT wrap: at most WIDTH hits, and CW holds WIDTH.
REQ-028 DONE SHALL last one cycle: done=1, done_id=cur_id, then last_served <= cur_id and go to IDLE.
REQ-029 hit_count and done_id SHALL hold their values after DONE until the next job's accept in IDLE.
REQ-030 det_bit SHALL be 0 outside SHIFT.
REQ-031 gnt0/gnt1 SHALL be 0 outside CLEAR, never both high.
REQ-032 Latency: req sampled at edge E0 -> gnt high in cycle E0+1 -> done high in cycle E0+WIDTH+2.
REQ-033 A req still high in IDLE after DONE SHALL be treated as a new job; there is no minimum IDLE dwell beyond one cycle.
REQ-034 A req asserted during busy SHALL wait; req and data changes while not in IDLE SHALL NOT affect the running job.

Reset
REQ-035 reset=1 at a rising edge SHALL force state=IDLE, last_served=1, and shreg, bit_idx, cur_id, hit_count, done_id = 0.
REQ-036 Reset output values: gnt0=gnt1=0, done=0, busy=0, det_bit=0, det_clear=1.
REQ-037 Reset mid-job (any state) SHALL abort the job with no done pulse; the requester must re-request.

Verification
REQ-038 req0=1, data0=8'b1011_1011 -> gnt0 one cycle later; done 9 cycles after gnt0; done_id=0, hit_count=2, any_hit=1.
REQ-039 req1=1, data1=8'h00 -> done_id=1, hit_count=0, any_hit=0; det_clear low for exactly 8 cycles.
REQ-040 req0 and req1 held high continuously from reset -> grants alternate 0,1,0,1; each done_id matches its preceding gnt.
REQ-041 data0=8'b0001_0110 -> hit_count=1; changing data0 mid-SHIFT does not change the result.
REQ-042 reset pulsed during the 4th SHIFT cycle -> no done; outputs at reset values next cycle; the following req0 is served normally.

Source files
------------

// File: rtl/detector_stream_arbiter.sv
// -----------------------------------------------------------------------------
// detector_stream_arbiter
//
// Purpose:
//   Accepts WIDTH-bit words from two requesters and serializes each word, MSB
//   first, into an external Mealy sequence detector. The detector's hit output
//   is counted over the word, and the count is reported with a one-cycle done
//   pulse. When both requesters are waiting, they are served in round-robin
//   order.
//
// Job flow (one state per line):
//   IDLE  -> CLEAR : a request is accepted. The winner's word is latched here.
//   CLEAR -> SHIFT : lasts one cycle. gnt for the winner pulses, and the
//                    detector is held in reset.
//   SHIFT -> DONE  : lasts WIDTH cycles. One bit per cycle goes out on det_bit,
//                    and det_hit is accumulated into hit_count.
//   DONE  -> IDLE  : lasts one cycle. done pulses with done_id / hit_count.
//
// Request/grant handshake:
//   reqN is a level request, and dataN must be stable while reqN is high. The
//   word is captured on the rising edge that moves IDLE -> CLEAR. gntN then
//   pulses high for exactly that following cycle, and the requester drops reqN
//   (or presents its next word) after seeing it. Any reqN that is still high
//   when the FSM is back in IDLE is a fresh job.
//
// Ports:
//   clock      in   rising-edge clock for all state
//   reset      in   synchronous, active-high reset
//   req0/1     in   job request from requester 0 / 1
//   data0/1    in   WIDTH-bit word of requester 0 / 1
//   gnt0/1     out  one-cycle accept pulse, to requester 0 / 1
//   det_clear  out  detector reset; low only while shifting
//   det_bit    out  detector serial input; 0 outside SHIFT
//   det_hit    in   detector Mealy output (combinational in det_bit)
//   busy       out  FSM is not in IDLE
//   done       out  one-cycle result-valid pulse
//   done_id    out  requester served by the latest job
//   hit_count  out  det_hit cycles counted during the latest job
//   any_hit    out  hit_count != 0
//   dbg_state  out  FSM state: 0 IDLE, 1 CLEAR, 2 SHIFT, 3 DONE
// -----------------------------------------------------------------------------
module detector_stream_arbiter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             det_clear,
  output logic             det_bit,
  input  logic             det_hit,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [CW-1:0]    hit_count,
  output logic             any_hit,
  output logic [1:0]       dbg_state
);

  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  logic [1:0]       state;
  logic             last_served;
  logic             cur_id;
  logic [WIDTH-1:0] shreg;
  logic [IW-1:0]    bit_idx;
  logic [CW-1:0]    hit_cnt_q;
  logic             done_id_q;
  logic             win_id;

  // Round-robin winner. When both requesters are asking, the one that was not
  // served last wins. A lone requester always wins. last_served resets to 1,
  // so requester 0 takes the first contested slot.
  always_comb begin
    win_id = 1'b0;
    if (req0 && req1) begin
      win_id = ~last_served;
    end else begin
      win_id = req1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      last_served <= 1'b1;
      cur_id      <= 1'b0;
      shreg       <= '0;
      bit_idx     <= '0;
      hit_cnt_q   <= '0;
      done_id_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            shreg     <= win_id ? data1 : data0;
            cur_id    <= win_id;
            bit_idx   <= '0;
            hit_cnt_q <= '0;
            state     <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          // At most WIDTH hits are possible, and CW always holds WIDTH,
          // so this count cannot wrap.
          hit_cnt_q <= hit_cnt_q + CW'(det_hit);
          shreg     <= {shreg[WIDTH-2:0], 1'b0};
          bit_idx   <= bit_idx + IW'(1);
          if (bit_idx == LAST_IDX) begin
            // done_id is loaded here so that it is already valid in DONE and
            // then holds until the next job finishes.
            done_id_q <= cur_id;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          last_served <= cur_id;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // All control outputs are decoded from the state, so they follow reset one
  // cycle later with no extra registers.
  assign gnt0      = (state == S_CLEAR) && !cur_id;
  assign gnt1      = (state == S_CLEAR) &&  cur_id;
  assign det_clear = (state != S_SHIFT);
  assign det_bit   = (state == S_SHIFT) ? shreg[WIDTH-1] : 1'b0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign done_id   = done_id_q;
  assign hit_count = hit_cnt_q;
  assign any_hit   = (hit_cnt_q != '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_detector_stream_arbiter.sv
module tb_detector_stream_arbiter;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int EW    = CW + 1;
  localparam int BOUND = 4 * WIDTH;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, det_clear, det_bit, det_hit;
  logic             busy, done, done_id, any_hit;
  logic [CW-1:0]    hit_count;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  // Each entry is {served id, expected hit count}.
  logic [EW-1:0] exp_q[$];
  logic          model_last;

  // ---------------------------------------------------------------- clock/reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------- DUT
  detector_stream_arbiter #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .data0     (data0),
    .data1     (data1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .det_clear (det_clear),
    .det_bit   (det_bit),
    .det_hit   (det_hit),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count),
    .any_hit   (any_hit),
    .dbg_state (dbg_state)
  );

  // Stand-in for the shared detector: an overlapping "1011" Mealy detector.
  logic [2:0] det_hist = 3'b000;
  always @(posedge clock) begin
    if (det_clear) det_hist <= 3'b000;
    else           det_hist <= {det_hist[1:0], det_bit};
  end
  assign det_hit = !det_clear && ({det_hist, det_bit} == 4'b1011);

  // ------------------------------------------------------- reference model
  // Number of (overlapping) "1011" windows in the word, read MSB first.
  function automatic int ref_hits(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = WIDTH - 1; i >= 3; i--) begin
      if (w[i -: 4] == 4'b1011) n++;
    end
    return n;
  endfunction

  // --------------------------------------------------------- driver tasks
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_last = 1'b1;
    exp_q.delete();
  endtask

  // Serve up to njobs jobs from the currently raised requests. In hold mode,
  // requesters keep req high and present a new random word after each gnt.
  // In scramble mode, both data inputs are randomized every cycle while busy.
  task automatic serve_jobs(input int njobs, input bit hold, input bit scramble);
    int               waited;
    int               shifts;
    logic             got_id;
    logic             exp_id;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] obs;
    logic [EW-1:0]    exp;
    for (int j = 0; j < njobs; j++) begin
      if (!(req0 || req1)) break;
      exp_id = (req0 && req1) ? ~model_last : req1;
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
      end while (!(gnt0 || gnt1) && waited < BOUND);
      checks++;
      if (!(gnt0 || gnt1)) begin
        errors++;
        $display("FAIL gnt_timeout: no grant after %0d cycles, required a grant", waited);
        return;
      end
      checks++;
      if (waited != 1) begin
        errors++;
        $display("FAIL gnt_latency: got %0d cycles, required 1", waited);
      end
      checks++;
      if (gnt0 && gnt1) begin
        errors++;
        $display("FAIL gnt_both: gnt0=%0b gnt1=%0b, required one-hot", gnt0, gnt1);
      end
      got_id = gnt1;
      checks++;
      if (got_id !== exp_id) begin
        errors++;
        $display("FAIL arb_winner: got %0b, required %0b", got_id, exp_id);
      end
      acc = got_id ? data1 : data0;
      exp_q.push_back({got_id, CW'(ref_hits(acc))});
      if (hold) begin
        if (got_id) data1 = WIDTH'($urandom);
        else        data0 = WIDTH'($urandom);
      end else begin
        if (got_id) req1 = 1'b0;
        else        req0 = 1'b0;
      end

      shifts = 0;
      obs    = '0;
      waited = 0;
      do begin
        @(negedge clock);
        waited++;
        if (scramble) begin
          data0 = WIDTH'($urandom);
          data1 = WIDTH'($urandom);
        end
        if (!det_clear) begin
          shifts++;
          obs = {obs[WIDTH-2:0], det_bit};
        end else begin
          checks++;
          if (det_bit !== 1'b0) begin
            errors++;
            $display("FAIL det_bit_idle: got %0b, required 0", det_bit);
          end
        end
        checks++;
        if (gnt0 || gnt1) begin
          errors++;
          $display("FAIL gnt_extra: gnt0=%0b gnt1=%0b, required 0 0", gnt0, gnt1);
        end
      end while (!done && waited < BOUND);
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL done_timeout: no done after %0d cycles, required done", waited);
        return;
      end
      checks++;
      if (waited != WIDTH + 1) begin
        errors++;
        $display("FAIL done_latency: got %0d cycles after gnt, required %0d", waited, WIDTH + 1);
      end
      checks++;
      if (shifts != WIDTH) begin
        errors++;
        $display("FAIL shift_cycles: det_clear low %0d cycles, required %0d", shifts, WIDTH);
      end
      checks++;
      if (obs !== acc) begin
        errors++;
        $display("FAIL serial_bits: got %b, required %b", obs, acc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got 0 entries, required 1");
        return;
      end
      exp = exp_q.pop_front();
      checks++;
      if (done_id !== exp[CW]) begin
        errors++;
        $display("FAIL done_id: got %0b, required %0b", done_id, exp[CW]);
      end
      checks++;
      if (hit_count !== exp[CW-1:0]) begin
        errors++;
        $display("FAIL hit_count: got %0d, required %0d", hit_count, exp[CW-1:0]);
      end
      checks++;
      if (any_hit !== (exp[CW-1:0] != '0)) begin
        errors++;
        $display("FAIL any_hit: got %0b, required %0b", any_hit, (exp[CW-1:0] != '0));
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_done: got %0b, required 1", busy);
      end
      model_last = got_id;
      if (hold && j == njobs - 1) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || det_clear !== 1'b1) begin
        errors++;
        $display("FAIL idle_after_done: busy=%0b done=%0b det_clear=%0b, required 0 0 1",
                 busy, done, det_clear);
      end
      checks++;
      if (hit_count !== exp[CW-1:0] || done_id !== exp[CW]) begin
        errors++;
        $display("FAIL result_hold: hit_count=%0d done_id=%0b, required %0d %0b",
                 hit_count, done_id, exp[CW-1:0], exp[CW]);
      end
    end
  endtask

  // -------------------------------------------------------- test scenarios
  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = WIDTH'($urandom);
    data1 = WIDTH'($urandom);
    repeat (2) @(negedge clock);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: gnt0=%0b gnt1=%0b, required 0 0", gnt0, gnt1);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: busy=%0b done=%0b, required 0 0", busy, done);
    end
    checks++;
    if (det_clear !== 1'b1 || det_bit !== 1'b0) begin
      errors++;
      $display("FAIL reset_det: det_clear=%0b det_bit=%0b, required 1 0", det_clear, det_bit);
    end
    checks++;
    if (hit_count !== '0 || done_id !== 1'b0 || any_hit !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: hit_count=%0d done_id=%0b any_hit=%0b, required 0 0 0",
               hit_count, done_id, any_hit);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    req0  = 1'b0;
    req1  = 1'b0;
    reset = 1'b0;
    model_last = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req: busy=%0b, required 0", busy);
      end
    end
  endtask

  task automatic test_single_req0();
    data0 = 8'b1011_1011;
    req0  = 1'b1;
    serve_jobs(1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_req1();
    data1 = 8'h00;
    req1  = 1'b1;
    serve_jobs(1, 1'b0, 1'b0);
  endtask

  task automatic test_mid_shift_change();
    data0 = 8'b0001_0110;
    req0  = 1'b1;
    serve_jobs(1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    reset = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = WIDTH'($urandom);
    data1 = WIDTH'($urandom);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_last = 1'b1;
    exp_q.delete();
    serve_jobs(4, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_job();
    int waited;
    int done_seen;
    data0 = WIDTH'($urandom);
    req0  = 1'b1;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!gnt0 && waited < BOUND);
    checks++;
    if (!gnt0) begin
      errors++;
      $display("FAIL abort_gnt_timeout: no gnt0 after %0d cycles, required gnt0", waited);
    end
    req0 = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (det_clear !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_shift: det_clear=%0b, required 0", det_clear);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_last = 1'b1;
    exp_q.delete();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 ||
        det_clear !== 1'b1 || det_bit !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%0b done=%0b gnt=%0b%0b det_clear=%0b det_bit=%0b, required 0 0 00 1 0",
               busy, done, gnt0, gnt1, det_clear, det_bit);
    end
    checks++;
    if (hit_count !== '0 || done_id !== 1'b0) begin
      errors++;
      $display("FAIL abort_result: hit_count=%0d done_id=%0b, required 0 0", hit_count, done_id);
    end
    done_seen = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clock);
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d active cycles, required 0", done_seen);
    end
    data0 = WIDTH'($urandom);
    req0  = 1'b1;
    serve_jobs(1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int pat;
    for (int it = 0; it < 25; it++) begin
      pat   = $urandom_range(1, 3);
      data0 = WIDTH'($urandom);
      data1 = WIDTH'($urandom);
      req0  = pat[0];
      req1  = pat[1];
      serve_jobs(2, 1'b0, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
  endtask

  // ------------------------------------------------------------- main + report
  initial begin
    reset      = 1'b1;
    req0       = 1'b0;
    req1       = 1'b0;
    data0      = '0;
    data1      = '0;
    model_last = 1'b1;
    test_reset();
    test_single_req0();
    test_zero_req1();
    test_mid_shift_change();
    test_back_to_back();
    test_reset_mid_job();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
